chunked_seq_adder: RTL and testbench



---
 rtl/chunked_seq_adder.sv | 136 +++++++++++++
 tb/tb_chunked_seq_adder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_seq_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | chunked_seq_adder                                                        |
// | Serial add/subtract of two WIDTH-bit operands, CHUNK bits per clock,     |
// | through one CHUNK-bit adder slice, with valid/ready on both sides.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module chunked_seq_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] C_LAST = IW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;

  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK:0]   w_sum;
  logic             w_ovf;
  logic             w_accept;
  logic             w_last;

  // Single shared slice: selects the active chunk of the latched operands.
  always_comb begin
    w_a_chunk = r_a[r_idx*CHUNK +: CHUNK];
    w_b_chunk = r_b[r_idx*CHUNK +: CHUNK];
    w_sum     = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
    // Carry into the MSB is recovered from the MSB's own sum bit.
    w_ovf     = w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1] ^ w_sum[CHUNK-1] ^ w_sum[CHUNK];
  end

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_last   = (r_idx == C_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      // Subtraction is A + ~B + ~borrow; inversion happens once at capture.
      r_a     <= A;
      r_b     <= sub ? ~B : B;
      r_carry <= sub ? ~Cin : Cin;
      r_idx   <= '0;
      r_s     <= '0;
    end else if (r_state == BUSY) begin
      r_s[r_idx*CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
      r_carry                   <= w_sum[CHUNK];
      if (w_last) begin
        r_cout <= w_sum[CHUNK];
        r_ovf  <= w_ovf;
      end else begin
        r_idx  <= r_idx + IW'(1);
      end
    end
  end

  assign S    = r_s;
  assign Cout = r_cout;
  assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_chunked_seq_adder.sv
`default_nettype none
// Directed bench for chunked_seq_adder: a 16/4 instance plus 4/1 and 4/4
// instances swept exhaustively against a full-width reference.
module tb_chunked_seq_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        in_valid = 1'b0, in_ready, cin = 1'b0, sb = 1'b0;
  logic        out_valid, out_ready = 1'b0, cout, ov;
  logic [15:0] a = '0, b = '0, s;

  chunked_seq_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .Cin(cin), .sub(sb), .out_valid(out_valid),
    .out_ready(out_ready), .S(s), .Cout(cout), .ovf(ov)
  );

  // Index 0: WIDTH=4/CHUNK=1, index 1: WIDTH=4/CHUNK=4
  logic       sv_in_valid[2], sv_in_ready[2], sv_cin[2], sv_sub[2];
  logic       sv_out_valid[2], sv_out_ready[2], sv_cout[2], sv_ovf[2];
  logic [3:0] sv_a[2], sv_b[2], sv_s[2];

  chunked_seq_adder #(.WIDTH(4), .CHUNK(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(sv_in_valid[0]), .in_ready(sv_in_ready[0]),
    .A(sv_a[0]), .B(sv_b[0]), .Cin(sv_cin[0]), .sub(sv_sub[0]),
    .out_valid(sv_out_valid[0]), .out_ready(sv_out_ready[0]),
    .S(sv_s[0]), .Cout(sv_cout[0]), .ovf(sv_ovf[0])
  );

  chunked_seq_adder #(.WIDTH(4), .CHUNK(4)) u_s4 (
    .clk(clk), .rst(rst), .in_valid(sv_in_valid[1]), .in_ready(sv_in_ready[1]),
    .A(sv_a[1]), .B(sv_b[1]), .Cin(sv_cin[1]), .sub(sv_sub[1]),
    .out_valid(sv_out_valid[1]), .out_ready(sv_out_ready[1]),
    .S(sv_s[1]), .Cout(sv_cout[1]), .ovf(sv_ovf[1])
  );

  // Full-width reference: {Cout, ovf, S}
  function automatic logic [5:0] ref4(input logic [3:0] x, input logic [3:0] y,
                                      input logic c, input logic m);
    logic [3:0] yy;
    logic       cc;
    logic [4:0] r;
    logic       v;
    yy = m ? ~y : y;
    cc = m ? ~c : c;
    r  = {1'b0, x} + {1'b0, yy} + {4'b0, cc};
    v  = (x[3] == yy[3]) && (r[3] != x[3]);
    return {r[4], v, r[3:0]};
  endfunction

  task automatic do_op16(input logic [15:0] xa, input logic [15:0] xb,
                         input logic xc, input logic xm,
                         output logic [15:0] rs, output logic rc,
                         output logic rv, output int lat);
    @(posedge clk); #1;
    a = xa; b = xb; cin = xc; sb = xm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rs = s; rc = cout; rv = ov;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || s !== 16'h0 ||
        cout !== 1'b0 || ov !== 1'b0) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b S=%h C=%b V=%b, want 1 0 0000 0 0",
               in_ready, out_valid, s, cout, ov);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_vec(input string nm, input logic [15:0] xa,
                          input logic [15:0] xb, input logic xc, input logic xm,
                          input logic [15:0] es, input logic ec, input logic ev);
    logic [15:0] rs;
    logic        rc, rv;
    int          lat;
    do_op16(xa, xb, xc, xm, rs, rc, rv, lat);
    checks++;
    if (rs !== es || rc !== ec || rv !== ev || lat != 4) begin
      errors++;
      $display("FAIL %s: S=%h C=%b V=%b lat=%0d, want S=%h C=%b V=%b lat=4",
               nm, rs, rc, rv, lat, es, ec, ev);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    @(posedge clk); #1;
    a = 16'h1234; b = 16'h4321; cin = 1'b0; sb = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || s !== 16'h5555 ||
          cout !== 1'b0 || ov !== 1'b0) begin
        errors++;
        $display("FAIL backpressure[%0d]: vld=%b rdy=%b S=%h C=%b V=%b, want 1 0 5555 0 0",
                 i, out_valid, in_ready, s, cout, ov);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release: vld=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1; sb = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || s !== 16'h0 ||
        cout !== 1'b0 || ov !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: rdy=%b vld=%b S=%h C=%b V=%b, want 1 0 0000 0 0",
               in_ready, out_valid, s, cout, ov);
    end
    #1;
    rst = 1'b0;
    test_vec("after_reset", 16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int first = -1, second = -1;
    logic [15:0] s_first = '0;
    @(posedge clk); #1;
    a = 16'h00FF; b = 16'h0F01; cin = 1'b0; sb = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (out_valid && first < 0) begin
        first = e;
        s_first = s;
      end else if (out_valid && first >= 0 && second < 0 && e > first + 1) begin
        second = e;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (first != 5 || second != 11 || s_first !== 16'h1000) begin
      errors++;
      $display("FAIL back_to_back: first=%0d second=%0d S=%h, want 5 11 1000",
               first, second, s_first);
    end
  endtask

  task automatic run_small(input int k, input logic [3:0] xa, input logic [3:0] xb,
                           input logic xc, input logic xm);
    logic [5:0] exp;
    int         lat, want;
    want = (k == 0) ? 4 : 1;
    exp  = ref4(xa, xb, xc, xm);
    @(posedge clk); #1;
    sv_a[k] = xa; sv_b[k] = xb; sv_cin[k] = xc; sv_sub[k] = xm; sv_in_valid[k] = 1'b1;
    @(posedge clk); #1;
    sv_in_valid[k] = 1'b0;
    lat = 0;
    while (!sv_out_valid[k] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if ({sv_cout[k], sv_ovf[k], sv_s[k]} !== exp || lat != want) begin
      errors++;
      $display("FAIL sweep%0d a=%h b=%h c=%b m=%b: S=%h C=%b V=%b lat=%0d, want S=%h C=%b V=%b lat=%0d",
               k, xa, xb, xc, xm, sv_s[k], sv_cout[k], sv_ovf[k], lat,
               exp[3:0], exp[5], exp[4], want);
    end
    sv_out_ready[k] = 1'b1;
    @(posedge clk); #1;
    sv_out_ready[k] = 1'b0;
  endtask

  task automatic test_sweep();
    for (int k = 0; k < 2; k++)
      for (int m = 0; m < 2; m++)
        for (int x = 0; x < 16; x++)
          for (int y = 0; y < 16; y++)
            for (int c = 0; c < 2; c++)
              run_small(k, 4'(x), 4'(y), 1'(c), 1'(m));
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      sv_in_valid[k] = 1'b0; sv_out_ready[k] = 1'b0; sv_cin[k] = 1'b0;
      sv_sub[k] = 1'b0; sv_a[k] = '0; sv_b[k] = '0;
    end
    test_reset();
    test_vec("add_carry", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    test_vec("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    test_vec("sub_neg",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    test_vec("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    test_vec("sub_borrow", 16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0);
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
